// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path: frame states,
// data width and parity-type encodings.
package uart_tx_pkg;

  localparam int DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A conforming serializer finishes after 8 shifts; a 9th means it is stuck.
  localparam logic [3:0] SAFETY_SHIFTS = 4'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: XOR-reduce of the byte, inverted for odd parity.
// Shared by the TX controller and the RX parity checker.
module parity_calc #(
  parameter int DATA_W = uart_tx_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              PAR_TYP,
  output logic              par_bit
);
  import uart_tx_pkg::*;

  assign par_bit = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: sequences start/data/parity/stop around an external
// LSB-first serializer and drives the TX line.
module uart_tx_ctrl #(
  parameter int DATA_W = uart_tx_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              SER_DATA,
  input  logic              SER_DONE,
  output logic              SER_EN,
  output logic              Busy,
  output logic              TX_OUT
);
  import uart_tx_pkg::*;

  tx_state_e  state;
  logic       par_bit;
  logic       par_bit_q;
  logic       par_en_q;
  logic [3:0] shift_cnt;

  parity_calc #(.DATA_W(DATA_W)) u_parity (
    .P_DATA  (P_DATA),
    .PAR_TYP (PAR_TYP),
    .par_bit (par_bit)
  );

  // SER_DONE is only trusted in DATA; in START it may still be high from the last frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      shift_cnt <= 4'd0;
    end else begin
      if (state == IDLE)
        shift_cnt <= 4'd0;
      else if (SER_EN && shift_cnt != 4'hF)
        shift_cnt <= shift_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit;
            state     <= START;
          end
        end
        START:  state <= DATA;
        DATA: begin
          if (SER_DONE)
            state <= par_en_q ? PARITY : STOP;
          else if (shift_cnt >= SAFETY_SHIFTS)
            state <= STOP;
        end
        PARITY: state <= STOP;
        STOP:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state, latched frame settings and the serializer bit.
  always_comb begin
    TX_OUT = 1'b1;
    Busy   = 1'b1;
    SER_EN = 1'b0;
    case (state)
      IDLE:   Busy = 1'b0;
      START: begin
        TX_OUT = 1'b0;
        SER_EN = 1'b1;
      end
      DATA: begin
        TX_OUT = SER_DATA;
        SER_EN = !SER_DONE;
      end
      PARITY: TX_OUT = par_bit_q;
      STOP:   TX_OUT = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a byte handshake and drives the 8-bit LSB-first serializer through `SER_EN` and `Busy`. It computes optional parity and multiplexes start, data, parity and stop bits onto the serial line `TX_OUT`. It sits alongside the serializer: it shares the serializer's `P_DATA`/`DATA_VALID` inputs, consumes its `SER_DATA`/`SER_DONE`, and is the last stage before the pad. One bit is transmitted per `CLK` cycle; baud pacing is applied upstream via clock/enable.

## Interface
- `DATA_W`, default 8: data width. It must match the serializer.
- `CLK`  in  1: clock. All state changes on its rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `P_DATA`  in  8: parallel byte. Used here only for parity.
- `DATA_VALID`  in  1: byte request. Accepted in a cycle where `DATA_VALID && !Busy`.
- `PAR_EN`  in  1: 1 inserts a parity bit.
- `PAR_TYP`  in  1: 0 selects even parity, 1 selects odd.
- `SER_DATA`  in  1: registered serial bit from the serializer.
- `SER_DONE`  in  1: serializer flag. It is high in the cycle `SER_DATA` holds the 8th (MSB) bit.
- `SER_EN`  out  1: shift enable to the serializer.
- `Busy`  out  1: frame in progress. It blocks the serializer's load.
- `TX_OUT`  out  1: UART line, idle high.

## Operation
- States (encoded in the package): IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `TX_OUT`=1, `Busy`=0, `SER_EN`=0.
  - On `DATA_VALID`: latch `PAR_EN` into `par_en_q` and `^P_DATA ^ PAR_TYP` into `par_bit_q`, then go to START. The serializer loads the same byte in the same cycle.
- **START**
  - `TX_OUT`=0, `Busy`=1, `SER_EN`=1. The first shift puts bit0 on `SER_DATA`.
  - Go to DATA.
- **DATA**
  - `TX_OUT`=`SER_DATA`, `Busy`=1, `SER_EN`=`!SER_DONE`.
  - When `SER_DONE`=1 (MSB cycle), go to PARITY if `par_en_q`, else STOP.
  - `SER_DONE` is not examined in START, because it may be stale high from the previous frame.
- **PARITY**
  - `TX_OUT`=`par_bit_q`, `Busy`=1, `SER_EN`=0.
  - Go to STOP.
- **STOP**
  - `TX_OUT`=1, `Busy`=1, `SER_EN`=0.
  - Go to IDLE.
- Outputs are decoded combinationally from the state register and registered inputs only. There is no path from `DATA_VALID` to any output.
- `P_DATA`, `PAR_EN` and `PAR_TYP` changing mid-frame have no effect.
- `DATA_VALID` while `Busy`=1 is ignored, not queued. The requester must hold it until it is accepted.
- Safety counter: a 4-bit shift counter increments on each cycle with `SER_EN`=1 and clears in IDLE.
  - If the counter reaches 9 in DATA without `SER_DONE`, force STOP (frame truncated, line restored high).
  - This cannot occur with a conforming serializer.
- Illegal state encodings return to IDLE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `TX_OUT`=1, `Busy`=0, `SER_EN`=0, `par_bit_q`=0, `par_en_q`=0, counter=0.
- Reset mid-frame returns the line high at once. The next frame starts cleanly because the serializer reloads.
- Accept in cycle k gives:
  - START in k+1;
  - data bits 0..7 in k+2..k+9;
  - parity in k+10 (if enabled);
  - STOP in k+10 or k+11;
  - IDLE in k+11 or k+12.
- Frame length is 10 cycles without parity and 11 with parity, plus at least 1 IDLE cycle before the next accept.
- Minimum spacing between accepts: 11 cycles without parity, 12 with parity.
- `Busy` rises the cycle after accept and falls on entry to IDLE.
- `SER_EN` is high for exactly 8 cycles per frame: START plus the first 7 DATA cycles.

## Structure
- Package `uart_tx_pkg`: state enum/localparams, `DATA_W`, parity-type constants (`PAR_EVEN`=0, `PAR_ODD`=1).
- Sub-module `parity_calc`: combinational XOR-reduce of `P_DATA` with `PAR_TYP`. It is reused later by the RX parity checker.
- Top level: state register, next-state logic, output decode, safety counter.

## Test plan
- Byte 0xA5, `PAR_EN`=1, `PAR_TYP`=0, accepted at cycle k -> `TX_OUT` from k+1 is 0,1,0,1,0,0,1,0,1,0,1, then IDLE 1 at k+12. `SER_EN` is high k+1..k+8.
- Byte 0xA5, `PAR_TYP`=1 -> parity bit at k+10 is 1. Byte 0x00, `PAR_TYP`=0 -> parity 0.
- Byte 0xFF, `PAR_EN`=0 -> `TX_OUT` sequence 0, eight 1s, 1 (stop). `Busy` is high for exactly 10 cycles.
- `DATA_VALID` held continuously with bytes 0x01 then 0x80 -> second accept exactly 12 cycles (parity on) after the first. Pulses during `Busy` are ignored. `P_DATA` changed mid-frame does not alter the parity bit.
- `RST` asserted during DATA bit 4 -> `TX_OUT`=1, `Busy`=0 immediately. The next 0x3C frame after release is bit-exact.
- Stub serializer that never asserts `SER_DONE` -> controller enters STOP after 9 shifts and returns to IDLE with the line high.
